// File: rtl/countdown_sequencer.sv
// Parametrised countdown sequencer: N_STEPS display steps of FRAMES_PER_STEP
// frame ticks each, then holds and raises the gameplay start level.
module countdown_sequencer #(
    parameter int                   N_STEPS         = 4,
    parameter int                   FRAMES_PER_STEP = 60,
    parameter int                   CW              = 6,
    parameter int                   SW              = 3,
    parameter logic [8*N_STEPS-1:0] STEP_COLORS     = {8'b011_100_01, 8'b111_000_11,
                                                       8'b010_100_11, 8'b010_001_10},
    parameter logic [7:0]           BG_COLOR        = 8'b111_111_11,
    parameter bit                   SHOW_IN_HOLD    = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               count_can_start,
    input  logic               pause,
    input  logic [N_STEPS-1:0] text_hit,
    output logic [SW-1:0]      step_idx,
    output logic               step_active,
    output logic               trigger_gameplay_start,
    output logic               done_pulse,
    output logic [7:0]         pixel_color
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [CW-1:0] LAST_FRAME = CW'(FRAMES_PER_STEP - 1);
    localparam logic [SW-1:0] LAST_STEP  = SW'(N_STEPS - 1);
    localparam logic [7:0]    LAST_COLOR = STEP_COLORS[8*(N_STEPS-1) +: 8];

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          cur_hit;
    logic [7:0]    cur_color;
    logic [7:0]    next_pix;

    // Only the current step's hit bit and colour matter.
    always_comb begin
        cur_hit   = 1'b0;
        cur_color = BG_COLOR;
        for (int i = 0; i < N_STEPS; i++) begin
            if (step_idx == SW'(i)) begin
                cur_hit   = text_hit[i];
                cur_color = STEP_COLORS[8*i +: 8];
            end
        end
    end

    always_comb begin
        next_pix = BG_COLOR;
        if (count_can_start) begin
            if (state == RUN && cur_hit)
                next_pix = cur_color;
            else if (state == HOLD && SHOW_IN_HOLD && text_hit[N_STEPS-1])
                next_pix = LAST_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            step_idx               <= '0;
            frame_cnt              <= '0;
            step_active            <= 1'b0;
            trigger_gameplay_start <= 1'b0;
            done_pulse             <= 1'b0;
            pixel_color            <= BG_COLOR;
        end else begin
            done_pulse  <= 1'b0;
            pixel_color <= next_pix;
            if (!count_can_start) begin
                state                  <= IDLE;
                step_idx               <= '0;
                frame_cnt              <= '0;
                step_active            <= 1'b0;
                trigger_gameplay_start <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= RUN;
                        step_idx    <= '0;
                        frame_cnt   <= '0;
                        step_active <= 1'b1;
                    end
                    RUN: begin
                        // Paused ticks are dropped, not queued.
                        if (frame_tick && !pause) begin
                            if (frame_cnt < LAST_FRAME) begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end else begin
                                frame_cnt <= '0;
                                if (step_idx < LAST_STEP) begin
                                    step_idx <= step_idx + 1'b1;
                                end else begin
                                    state                  <= HOLD;
                                    step_active            <= 1'b0;
                                    trigger_gameplay_start <= 1'b1;
                                    done_pulse             <= 1'b1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Parametrised successor to the fixed 3-2-1-START countdown block.
- Sequences N_STEPS display steps, each lasting FRAMES_PER_STEP frame ticks, then holds and asserts gameplay start.
- Adds pause, a one-cycle done pulse, a step-index output and a per-step colour table.
- Runs on the single system clock; frame timing comes from a one-cycle frame_tick enable, not a second clock.
- Sits between the game-state controller and the VGA pixel mux. Text rasterisers stay external and feed per-step hit bits.

Parameters:
- N_STEPS, 4, number of countdown steps (2..8).
- FRAMES_PER_STEP, 60, frame ticks per step (2..2^CW).
- CW, 6, frame counter width.
- SW, 3, step index width; must satisfy 2^SW >= N_STEPS.
- STEP_COLORS, {8'b011_100_01, 8'b111_000_11, 8'b010_100_11, 8'b010_001_10}, flattened 8*N_STEPS RGB332 table; step 0 is in bits [7:0].
- BG_COLOR, 8'b111_111_11, background colour.
- SHOW_IN_HOLD, 0, when 1 the last step's text stays drawn during HOLD.

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-clk pulse per video frame
- count_can_start  in  1  level enable from game FSM
- pause  in  1  level; freezes the sequence
- text_hit  in  N_STEPS  bit i = current pixel lies on step i's text (already aligned to next_x/next_y)
- step_idx  out  SW  current step index
- step_active  out  1  high while in RUN
- trigger_gameplay_start  out  1  level, high in HOLD
- done_pulse  out  1  one clk high on entry to HOLD
- pixel_color  out  8  registered colour

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state = IDLE, step_idx = 0, frame counter = 0
  - step_active = 0, trigger_gameplay_start = 0, done_pulse = 0
  - pixel_color = BG_COLOR
- States are IDLE, RUN, HOLD; all transitions happen on the clk rising edge.
- IDLE:
  - If count_can_start = 1, go to RUN with step 0 and counter 0 on the next clk.
  - frame_tick is ignored in IDLE.
- RUN, on a clk with frame_tick = 1 and pause = 0:
  - If counter < FRAMES_PER_STEP-1: counter += 1.
  - Otherwise, counter = 0 and:
    - if step_idx < N_STEPS-1: step_idx += 1;
    - else: go to HOLD, done_pulse = 1 for that one clk.
- pause = 1 in RUN: counter and step_idx freeze and ticks are dropped, not queued. Display continues.
- HOLD:
  - trigger_gameplay_start = 1 as a registered output, so it is high from the first HOLD cycle.
  - step_idx stays at N_STEPS-1.
  - Ticks are ignored.
- count_can_start = 0 in any state: go to IDLE next clk, with step_idx = 0, counter = 0 and all status outputs low.
  - This has priority over frame_tick and pause.
  - Re-asserting count_can_start restarts from step 0.
- Each step lasts exactly FRAMES_PER_STEP ticks. Total ticks from RUN entry to HOLD = N_STEPS*FRAMES_PER_STEP.
- step_active = (state == RUN).
- done_pulse never lasts more than 1 clk. It does not re-fire while in HOLD.
- pixel_color is registered with 1 clk latency from text_hit and state. Priority:
  1. count_can_start = 0 or state = IDLE → BG_COLOR.
  2. RUN and text_hit[step_idx] = 1 → STEP_COLORS[8*step_idx +: 8].
  3. HOLD, SHOW_IN_HOLD = 1 and text_hit[N_STEPS-1] = 1 → last step's colour.
  4. Otherwise → BG_COLOR.
- text_hit bits for non-current steps are ignored.
- A frame_tick on the same clk as the RUN entry edge is not counted.
- Counter arithmetic is unsigned CW-bit. It can never wrap, because it is bounded by FRAMES_PER_STEP-1.
- Reset mid-sequence (e.g. step 2, counter 30) returns immediately to the reset values.
- After reset release, a sequence needs count_can_start high to start. If it is already high, RUN is entered on the first clk.

Test Plan:
- Default params, count_can_start = 1, tick every 10 clks → step_idx steps 0,1,2,3 after 60, 120, 180 ticks; HOLD and done_pulse (1 clk) on tick 240; trigger_gameplay_start stays 1.
- Pause held for 25 ticks during step 1, frame 30 → step 1 lasts 85 tick-times in total; step_idx = 2 at tick 145 instead of 120.
- count_can_start dropped at step 2 on the same clk as a tick → next clk is IDLE with step_idx = 0 and pixel_color = BG_COLOR; re-assert gives a full 240-tick sequence.
- text_hit = 4'b1111 while step_idx = 1 → pixel_color = 8'b010_100_11 one clk later; text_hit = 4'b1101 → BG_COLOR. In HOLD with SHOW_IN_HOLD = 0 → BG_COLOR.
- N_STEPS = 2, FRAMES_PER_STEP = 3, CW = 2, SW = 1 → HOLD after exactly 6 ticks; done_pulse is asserted once.
- reset_n pulsed low asynchronously between clk edges at step 3 → all outputs take their reset values without waiting for a clock edge; sequence restarts from step 0 after release.
